// File: rtl/shot_trigger.sv
// shot_trigger: light-gun trigger front end and Zapper-style flash sequencer.
//
// A raw trigger pull is synchronised, debounced and edge-detected. A pull while the game is
// in PLAY_STATE with shots remaining emits a one-cycle `shot`. The block then blanks the screen
// for FLASH_FRAMES frames and draws the target for TARGET_FRAMES frames while sampling
// `hit_sense`, and finally reports a one-cycle `hit` or `miss`. The trigger must be released
// before another shot can be taken.
//
// Ports:
//   Clk, Reset_n   clock, asynchronous active-low reset
//   trigger_raw    raw asynchronous trigger, 1 = pulled
//   state          game FSM state; shots are allowed only in PLAY_STATE
//   no_shots_left  1 = magazine empty
//   frame_start    one-cycle pulse at the start of each video frame
//   hit_sense      photodiode / hitbox overlap seen this cycle
//   shot           one-cycle pulse per accepted pull
//   flash_black    blank the screen
//   flash_target   draw the white target box
//   hit, miss      one-cycle result pulses, exactly one per completed sequence
//   busy           sequencer is not idle

module shot_trigger #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FLASH_FRAMES    = 1,
    parameter int unsigned TARGET_FRAMES   = 1,
    parameter logic [2:0]  PLAY_STATE      = 3'b010
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       trigger_raw,
    input  logic [2:0] state,
    input  logic       no_shots_left,
    input  logic       frame_start,
    input  logic       hit_sense,
    output logic       shot,
    output logic       flash_black,
    output logic       flash_target,
    output logic       hit,
    output logic       miss,
    output logic       busy
);

    localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned FRAME_MAX = (FLASH_FRAMES > TARGET_FRAMES) ? FLASH_FRAMES
                                                                       : TARGET_FRAMES;
    localparam int unsigned FR_W      = $clog2(FRAME_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0] FLASH_LAST  = FR_W'(FLASH_FRAMES - 1);
    localparam logic [FR_W-1:0] TARGET_LAST = FR_W'(TARGET_FRAMES - 1);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StShot      = 3'd1;
    localparam logic [2:0] StWaitFrame = 3'd2;
    localparam logic [2:0] StBlack     = 3'd3;
    localparam logic [2:0] StTarget    = 3'd4;
    localparam logic [2:0] StResult    = 3'd5;
    localparam logic [2:0] StRelease   = 3'd6;

    logic            trig_meta_q, trig_meta_d;
    logic            trig_s_q, trig_s_d;
    logic            trig_db_q, trig_db_d;
    logic            trig_db_dly_q, trig_db_dly_d;
    logic            pull_q, pull_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]      fsm_q, fsm_d;
    logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            hit_latch_q, hit_latch_d;

    logic in_play;

    assign in_play = (state == PLAY_STATE);

    // Synchroniser, debounce and registered rising-edge detect.
    always_comb begin
        trig_meta_d   = trigger_raw;
        trig_s_d      = trig_meta_q;
        trig_db_d     = trig_db_q;
        db_cnt_d      = '0;
        if (trig_s_q != trig_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                trig_db_d = trig_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        trig_db_dly_d = trig_db_q;
        pull_d        = trig_db_q & ~trig_db_dly_q;
    end

    always_comb begin
        fsm_d       = fsm_q;
        frame_cnt_d = frame_cnt_q;
        hit_latch_d = hit_latch_q;
        case (fsm_q)
            StIdle: begin
                // Pulls that arrive when shots are not allowed are dropped, not queued.
                if (pull_q && in_play && !no_shots_left) begin
                    fsm_d = StShot;
                end
            end
            StShot: begin
                fsm_d = StWaitFrame;
            end
            StWaitFrame: begin
                if (!in_play) begin
                    fsm_d = StRelease;
                end else if (frame_start) begin
                    fsm_d       = StBlack;
                    frame_cnt_d = '0;
                end
            end
            StBlack: begin
                if (!in_play) begin
                    fsm_d = StRelease;
                end else if (frame_start) begin
                    if (frame_cnt_q == FLASH_LAST) begin
                        fsm_d       = StTarget;
                        frame_cnt_d = '0;
                        hit_latch_d = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            StTarget: begin
                if (!in_play) begin
                    fsm_d = StRelease;
                end else begin
                    // hit_sense on the closing frame_start cycle still counts.
                    hit_latch_d = hit_latch_q | hit_sense;
                    if (frame_start) begin
                        if (frame_cnt_q == TARGET_LAST) begin
                            fsm_d       = StResult;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StResult: begin
                fsm_d = StRelease;
            end
            StRelease: begin
                if (!trig_db_q) begin
                    fsm_d = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            trig_meta_q   <= 1'b0;
            trig_s_q      <= 1'b0;
            trig_db_q     <= 1'b0;
            trig_db_dly_q <= 1'b0;
            pull_q        <= 1'b0;
            db_cnt_q      <= '0;
            fsm_q         <= StIdle;
            frame_cnt_q   <= '0;
            hit_latch_q   <= 1'b0;
        end else begin
            trig_meta_q   <= trig_meta_d;
            trig_s_q      <= trig_s_d;
            trig_db_q     <= trig_db_d;
            trig_db_dly_q <= trig_db_dly_d;
            pull_q        <= pull_d;
            db_cnt_q      <= db_cnt_d;
            fsm_q         <= fsm_d;
            frame_cnt_q   <= frame_cnt_d;
            hit_latch_q   <= hit_latch_d;
        end
    end

    // Outputs decode registered state only, so they fall with the asynchronous reset.
    always_comb begin
        shot         = (fsm_q == StShot);
        flash_black  = (fsm_q == StBlack);
        flash_target = (fsm_q == StTarget);
        hit          = (fsm_q == StResult) &  hit_latch_q;
        miss         = (fsm_q == StResult) & ~hit_latch_q;
        busy         = (fsm_q != StIdle);
    end

endmodule

// File: tb/tb_shot_trigger.sv
// tb_shot_trigger: randomized scoreboard bench for shot_trigger.
//
// Each transaction plans its whole stimulus timeline up front (trigger pull, frame pulses,
// hit_sense pattern, aborts, reset) and derives from it the cycle at which shot/hit/miss
// must appear and the cycle windows in which flash_black, flash_target and busy are high.
// A monitor compares the DUT against those expectations on every falling edge.

module tb_shot_trigger;

    localparam int unsigned D    = 4;
    localparam logic [2:0]  PLAY = 3'b010;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       trigger_raw = 1'b0;
    logic [2:0] state = PLAY;
    logic       no_shots_left = 1'b0;
    logic       frame_start = 1'b0;
    logic       hit_sense = 1'b0;
    logic       shot, flash_black, flash_target, hit, miss, busy;

    shot_trigger #(
        .DEBOUNCE_CYCLES(D),
        .FLASH_FRAMES   (1),
        .TARGET_FRAMES  (1),
        .PLAY_STATE     (PLAY)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .trigger_raw  (trigger_raw),
        .state        (state),
        .no_shots_left(no_shots_left),
        .frame_start  (frame_start),
        .hit_sense    (hit_sense),
        .shot         (shot),
        .flash_black  (flash_black),
        .flash_target (flash_target),
        .hit          (hit),
        .miss         (miss),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    // cyc = number of rising edges so far; stimulus set while cyc==n-1 is sampled at edge n.
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] kind;  // {miss, hit, shot}
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  check_en = 1'b0;
    int  blk_lo = 0, blk_hi = 0, tgt_lo = 0, tgt_hi = 0, bsy_lo = 0, bsy_hi = 0;

    task automatic check_bit(input string name, input logic got, input logic expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, expv);
        end
    endtask

    logic [2:0] mon_ev;
    ev_t        mon_e;

    always @(negedge Clk) begin
        if (check_en) begin
            mon_ev = {miss, hit, shot};
            if (mon_ev != 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got={miss,hit,shot}=%b required=none",
                             cyc, mon_ev);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.kind !== mon_ev || mon_e.at != cyc) begin
                        errors++;
                        $display("FAIL event got=%b@%0d required=%b@%0d",
                                 mon_ev, cyc, mon_e.kind, mon_e.at);
                    end
                end
            end
            check_bit("flash_black", flash_black, (cyc >= blk_lo) && (cyc < blk_hi));
            check_bit("flash_target", flash_target, (cyc >= tgt_lo) && (cyc < tgt_hi));
            check_bit("busy", busy, (cyc >= bsy_lo) && (cyc < bsy_hi));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic quiet();
        trigger_raw   = 1'b0;
        frame_start   = 1'b0;
        hit_sense     = 1'b0;
        state         = PLAY;
        no_shots_left = 1'b0;
    endtask

    task automatic clear_windows();
        blk_lo = 0; blk_hi = 0; tgt_lo = 0; tgt_hi = 0; bsy_lo = 0; bsy_hi = 0;
    endtask

    task automatic check_all_zero();
        check_bit("rst_shot", shot, 1'b0);
        check_bit("rst_flash_black", flash_black, 1'b0);
        check_bit("rst_flash_target", flash_target, 1'b0);
        check_bit("rst_hit", hit, 1'b0);
        check_bit("rst_miss", miss, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without an edge.
    task automatic do_reset();
        #2;
        check_en = 1'b0;
        Reset_n  = 1'b0;
        #1;
        check_all_zero();
        exp_q.delete();
        quiet();
        clear_windows();
        repeat (3) step();
        #2;
        Reset_n = 1'b1;
        step();
        check_en = 1'b1;
    endtask

    // Short trigger blip: never reaches the debounced level.
    task automatic run_glitch(input int len);
        int p;
        p = cyc + 1;
        clear_windows();
        for (int n = p; n <= p + len + int'(D) + 6; n++) begin
            trigger_raw = (n < p + len);
            step();
        end
        quiet();
    endtask

    // Pull while shots are not permitted (which: 0 = magazine empty, 1 = wrong game state).
    task automatic run_blocked(input int which);
        int p, r;
        p = cyc + 1;
        r = p + int'(D) + 3 + int'($urandom_range(1, 5));
        clear_windows();
        for (int n = p; n <= r + int'(D) + 4; n++) begin
            trigger_raw   = (n < r);
            no_shots_left = (which == 0);
            state         = (which == 1) ? 3'b001 : PLAY;
            step();
        end
        quiet();
    endtask

    // Full pull. mode: 0 single hit pulse in target window, 1 hit_sense only outside it,
    // 2 abort during black, 3 random hit_sense everywhere, 5 reset mid-target.
    task automatic run_pull(input int mode);
        int p, ts, f1, f2, f3, a, r, end_n;
        bit fs_extra, exp_hit;
        bit hs_arr[256];
        p  = cyc + 1;
        ts = p + int'(D) + 3;  // 2-flop sync + D debounce clocks + edge reg + FSM reg
        f1 = ts + 2 + int'($urandom_range(0, 4));
        f2 = f1 + int'($urandom_range(1, 5));
        f3 = f2 + ((mode == 5) ? int'($urandom_range(2, 5)) : int'($urandom_range(1, 5)));
        a  = int'($urandom_range(f1 + 1, f2));
        fs_extra = 1'($urandom_range(0, 1));
        for (int i = 0; i < 256; i++) hs_arr[i] = 1'b0;
        case (mode)
            0: hs_arr[int'($urandom_range(f2 + 1, f3)) - p] = 1'b1;
            1: begin
                for (int n = p; n <= f2; n++) hs_arr[n - p] = 1'($urandom_range(0, 1));
                for (int n = f3 + 1; n <= f3 + 8; n++) hs_arr[n - p] = 1'($urandom_range(0, 1));
            end
            default: for (int i = 0; i < 200; i++) hs_arr[i] = ($urandom_range(0, 3) == 0);
        endcase
        // The result reflects hit_sense seen while the target frame is on screen.
        exp_hit = 1'b0;
        for (int n = f2 + 1; n <= f3; n++) exp_hit |= hs_arr[n - p];
        r     = (mode == 2) ? a + 100 : f3 + int'($urandom_range(0, 5));
        end_n = r + int'(D) + 4;

        bsy_lo = ts;
        bsy_hi = r + int'(D) + 2;
        blk_lo = f1;
        blk_hi = (mode == 2) ? a : f2;
        tgt_lo = (mode == 2) ? 0 : f2;
        tgt_hi = (mode == 2) ? 0 : f3;
        exp_q.push_back('{kind: 3'b001, at: ts});
        if (mode != 2 && mode != 5) begin
            exp_q.push_back('{kind: (exp_hit ? 3'b010 : 3'b100), at: f3});
        end

        for (int n = p; n <= end_n; n++) begin
            trigger_raw = (n < r);
            frame_start = (n == f1) || (n == f2) || (n == f3) || (fs_extra && n == ts + 1);
            hit_sense   = hs_arr[n - p];
            state       = (mode == 2 && n >= a && n < r) ? 3'b011 : PLAY;
            step();
            if (mode == 5 && n == f2 + 1) begin
                do_reset();
                break;
            end
        end
        quiet();
    endtask

    initial begin
        quiet();
        Reset_n = 1'b0;
        #3;
        check_all_zero();
        repeat (2) step();
        #2;
        Reset_n = 1'b1;
        step();
        check_en = 1'b1;

        run_glitch(3);
        run_pull(0);
        run_pull(1);
        run_blocked(0);
        run_blocked(1);
        run_pull(0);
        run_pull(2);
        run_pull(5);
        run_pull(0);
        for (int k = 0; k < 30; k++) begin
            repeat (int'($urandom_range(1, 5))) step();
            case ($urandom_range(0, 6))
                0: run_pull(0);
                1: run_pull(1);
                2: run_pull(2);
                3: run_pull(3);
                4: run_pull(5);
                5: run_glitch(int'($urandom_range(1, D - 1)));
                default: run_blocked(int'($urandom_range(0, 1)));
            endcase
        end
        repeat (4) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d_pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
